// File: rtl/uart_tx_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_tx_queue_pkg
// Description : Shared constants and send-FSM encoding for the UART transmit
//               byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_queue_pkg;

   // Line framing characters used by the calculator output line.
   localparam logic [7:0] UART_CR = 8'h0D;
   localparam logic [7:0] UART_LF = 8'h0A;

   // Default guard gap (clk cycles) between handing a byte over and looking at
   // tx_sent again; covers the latency before uart_tx drops its idle flag.
   localparam int GAP_CYCLES_DEFAULT = 20;

   // Send FSM states.
   typedef enum logic [0:0] {
      SEND_IDLE = 1'b0,
      SEND_GAP  = 1'b1
   } send_state_e;

endpackage : uart_tx_queue_pkg
`default_nettype wire

// File: rtl/uart_tx_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue_sync_fifo
// Description : Single-clock FIFO with wrap-bit pointers. Push is ignored
//               while full and pop while empty, so callers may gate loosely.
//               Read data is the combinational head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wp_q;
   logic [AW:0]      rp_q;
   logic             w_do_push;
   logic             w_do_pop;

   // Occupancy is the pointer difference; the extra MSB tells full from empty.
   assign count_o    = wp_q - rp_q;
   assign full_o     = (count_o == (AW+1)'(DEPTH));
   assign empty_o    = (count_o == '0);
   assign w_do_push  = push_i & ~full_o;
   assign w_do_pop   = pop_i & ~empty_o;
   assign pop_data_o = mem_q[rp_q[AW-1:0]];

   // Pointer update; reset discards everything queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (w_do_push) wp_q <= wp_q + 1'b1;
         if (w_do_pop)  rp_q <= rp_q + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[wp_q[AW-1:0]] <= push_data_i;
   end

endmodule : uart_tx_queue_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Transmit byte queue in front of uart_tx. Accepts single bytes
//               or a packed output line, buffers them, and hands one byte at a
//               time to uart_tx with a 1-cycle enable followed by a guard gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int LINE_CHARS = 14,
   parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_valid,
   input  logic [7:0]                wr_data,
   output logic                      wr_ready,
   input  logic                      ld_start,
   input  logic [8*LINE_CHARS-1:0]   ld_line,
   input  logic [3:0]                ld_len,
   output logic                      ld_busy,
   output logic [7:0]                tx_data,
   output logic                      tx_en,
   input  logic                      tx_sent,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty,
   output logic                      overflow,
   output logic                      ld_err
);

   localparam int LEN_W = ($clog2(LINE_CHARS+1) > 4) ? $clog2(LINE_CHARS+1) : 4;
   localparam int GAP_W = ($clog2(GAP_CYCLES+1) > 1) ? $clog2(GAP_CYCLES+1) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(LINE_CHARS);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES-1);

   // FIFO interface
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic [7:0]              w_push_data;
   logic [7:0]              w_pop_data;

   // Loader
   logic                    ld_busy_q;
   logic [8*LINE_CHARS-1:0] line_q;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        w_ld_len;

   // Sticky flags
   logic                    overflow_q;
   logic                    ld_err_q;

   // Send FSM
   send_state_e             state_q, state_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [7:0]              tx_data_q, tx_data_d;
   logic                    tx_en_q, tx_en_d;

   uart_tx_queue_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (w_push),
      .push_data_i (w_push_data),
      .pop_i       (w_pop),
      .pop_data_o  (w_pop_data),
      .count_o     (count),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   // The loader owns the FIFO write port while busy, so direct pushes are
   // refused then; full refuses pushes even if a pop frees a slot this cycle.
   assign wr_ready    = ~w_full & ~ld_busy_q;
   assign w_push      = (ld_busy_q & ~w_full) | (wr_valid & wr_ready);
   assign w_push_data = ld_busy_q ? line_q[8*LINE_CHARS-1 -: 8] : wr_data;
   assign w_ld_len    = LEN_W'(ld_len);

   assign ld_busy  = ld_busy_q;
   assign empty    = w_empty;
   assign overflow = overflow_q;
   assign ld_err   = ld_err_q;
   assign tx_data  = tx_data_q;
   assign tx_en    = tx_en_q;

   // Line loader: latch the line, then drain its leading bytes one per
   // non-full cycle, stalling without loss when the FIFO is full.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_busy_q <= 1'b0;
         line_q    <= '0;
         len_q     <= '0;
      end else if (ld_busy_q) begin
         if (!w_full) begin
            line_q <= line_q << 8;
            len_q  <= len_q - 1'b1;
            if (len_q == LEN_W'(1)) ld_busy_q <= 1'b0;
         end
      end else if (ld_start && (ld_len != 4'd0)) begin
         line_q    <= ld_line;
         len_q     <= (w_ld_len > LEN_MAX) ? LEN_MAX : w_ld_len;
         ld_busy_q <= 1'b1;
      end
   end

   // Sticky error flags: dropped byte push, and line start while loading.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
         ld_err_q   <= 1'b0;
      end else begin
         if (wr_valid && !wr_ready) overflow_q <= 1'b1;
         if (ld_start && ld_busy_q) ld_err_q   <= 1'b1;
      end
   end

   // Send FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SEND_IDLE;
         gap_q     <= '0;
         tx_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
      end
   end

   // Send FSM next state: hand over one byte when uart_tx is idle, then sit
   // out GAP_CYCLES cycles before tx_sent is trusted again.
   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      tx_data_d = tx_data_q;
      tx_en_d   = 1'b0;
      w_pop     = 1'b0;
      case (state_q)
         SEND_IDLE: begin
            if (!w_empty && tx_sent) begin
               w_pop     = 1'b1;
               tx_data_d = w_pop_data;
               tx_en_d   = 1'b1;
               gap_d     = '0;
               state_d   = SEND_GAP;
            end
         end
         SEND_GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_LAST) state_d = SEND_IDLE;
         end
         default: state_d = SEND_IDLE;
      endcase
   end

endmodule : uart_tx_queue
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_queue
// Description : Self-checking bench for uart_tx_queue: a cycle-exact vector
//               table for the basic push/send path, then directed sequences
//               for line loading, full/overflow, loader stall, reset and
//               length clamping. Every tx_en is checked against an expected
//               byte queue, the tx_sent handshake and the minimum spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

   localparam int DEPTH = 16;
   localparam int LC    = 14;
   localparam int GAP   = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          wr_ready;
   logic          ld_start;
   logic [8*LC-1:0] ld_line;
   logic [3:0]    ld_len;
   logic          ld_busy;
   logic [7:0]    tx_data;
   logic          tx_en;
   logic          tx_sent;
   logic [4:0]    count;
   logic          empty;
   logic          overflow;
   logic          ld_err;

   uart_tx_queue #(
      .DEPTH      (DEPTH),
      .LINE_CHARS (LC),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .ld_start (ld_start),
      .ld_line  (ld_line),
      .ld_len   (ld_len),
      .ld_busy  (ld_busy),
      .tx_data  (tx_data),
      .tx_en    (tx_en),
      .tx_sent  (tx_sent),
      .count    (count),
      .empty    (empty),
      .overflow (overflow),
      .ld_err   (ld_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wv;
      logic [7:0] wd;
      logic       ls;
      logic [3:0] ll;
      logic       ts;
      logic [4:0] e_count;
      logic       e_rdy;
      logic       e_empty;
      logic       e_ovf;
      logic       e_busy;
      logic       e_txen;
      logic [7:0] e_txd;
   } vec_t;

   vec_t        tbl [7];
   logic [7:0]  exp_q [$];
   logic [7:0]  line1_b [LC];
   logic [7:0]  exp_b;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_tx = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   bit          has_last = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock: inputs set before the edge, outputs looked at 1 time unit
   // after it. Any tx_en pulse is checked against the expected byte queue,
   // the tx_sent value seen at the pop edge and the spacing to the last one.
   task automatic tick();
      logic ts_b;
      ts_b = tx_sent;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         has_last = 1'b0;
      end else if (tx_en) begin
         n_tx++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte %02h expected no tx_en", tx_data);
         end else begin
            exp_b = exp_q.pop_front();
            chk("tx_data_order", {24'h0, tx_data}, {24'h0, exp_b});
         end
         chk("tx_sent_at_pop", {31'h0, ts_b}, 32'd1);
         if (has_last) chk("tx_spacing_ge_gap_plus1", {31'h0, (cyc - last_cyc) >= (GAP + 1)}, 32'd1);
         has_last = 1'b1;
         last_cyc = cyc;
      end
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk("drain_remaining_bytes", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      ld_start = 1'b0;
      ld_len   = 4'd0;
      ld_line  = '0;
      tx_sent  = 1'b0;
      tick();
      tick();
      chk("rst_count",    {27'h0, count}, 32'd0);
      chk("rst_empty",    {31'h0, empty}, 32'd1);
      chk("rst_wr_ready", {31'h0, wr_ready}, 32'd1);
      chk("rst_ld_busy",  {31'h0, ld_busy}, 32'd0);
      chk("rst_overflow", {31'h0, overflow}, 32'd0);
      chk("rst_ld_err",   {31'h0, ld_err}, 32'd0);
      chk("rst_tx_en",    {31'h0, tx_en}, 32'd0);
      chk("rst_tx_data",  {24'h0, tx_data}, 32'd0);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic push_byte(input logic [7:0] b);
      wr_valid = 1'b1;
      wr_data  = b;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic start_line(input logic [3:0] len);
      ld_len   = len;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   initial begin
      int n_before;
      logic [8*LC-1:0] line1;

      line1_b = '{8'h0D, 8'h0A, 8'h2B, 8'h28, 8'h20, 8'h30, 8'h30,
                  8'h31, 8'h32, 8'h20, 8'h29, 8'h20, 8'h3A, 8'h20};
      line1 = '0;
      for (int i = 0; i < LC; i++) line1 = {line1[8*LC-9:0], line1_b[i]};

      //          wv    wd     ls    ll    ts    cnt    rdy   emp   ovf   busy  txen  txd
      tbl[0] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 8'h41, 1'b0, 4'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b1, 8'h42, 1'b0, 4'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
      tbl[6] = '{1'b1, 8'h43, 1'b0, 4'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};

      // Test 1: reset values and cycle-exact push / first send / ld_len==0.
      do_reset();
      exp_q = '{8'h41, 8'h42, 8'h43};
      for (int i = 0; i < 7; i++) begin
         wr_valid = tbl[i].wv;
         wr_data  = tbl[i].wd;
         ld_start = tbl[i].ls;
         ld_len   = tbl[i].ll;
         tx_sent  = tbl[i].ts;
         tick();
         chk($sformatf("v%0d_count", i),    {27'h0, count},    {27'h0, tbl[i].e_count});
         chk($sformatf("v%0d_wr_ready", i), {31'h0, wr_ready}, {31'h0, tbl[i].e_rdy});
         chk($sformatf("v%0d_empty", i),    {31'h0, empty},    {31'h0, tbl[i].e_empty});
         chk($sformatf("v%0d_overflow", i), {31'h0, overflow}, {31'h0, tbl[i].e_ovf});
         chk($sformatf("v%0d_ld_busy", i),  {31'h0, ld_busy},  {31'h0, tbl[i].e_busy});
         chk($sformatf("v%0d_tx_en", i),    {31'h0, tx_en},    {31'h0, tbl[i].e_txen});
         chk($sformatf("v%0d_tx_data", i),  {24'h0, tx_data},  {24'h0, tbl[i].e_txd});
      end
      wr_valid = 1'b0;
      ld_start = 1'b0;
      tx_sent  = 1'b1;
      wait_drain(200);
      chk("t1_count_zero", {27'h0, count}, 32'd0);
      chk("t1_empty", {31'h0, empty}, 32'd1);

      // Test 2: full 14-char line goes out in order with guard gaps.
      do_reset();
      tx_sent = 1'b1;
      ld_line = line1;
      for (int i = 0; i < LC; i++) exp_q.push_back(line1_b[i]);
      start_line(4'd14);
      chk("t2_ld_busy_after_start", {31'h0, ld_busy}, 32'd1);
      chk("t2_wr_ready_busy", {31'h0, wr_ready}, 32'd0);
      wait_drain(600);
      chk("t2_ld_busy_done", {31'h0, ld_busy}, 32'd0);
      chk("t2_count_zero", {27'h0, count}, 32'd0);

      // Test 3: fill while uart_tx busy, overflow on the 17th push, drain.
      do_reset();
      tx_sent = 1'b1;
      exp_q.push_back(8'h50);
      push_byte(8'h50);
      wait_drain(50);
      tx_sent = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'h60 + 8'(i));
         push_byte(8'h60 + 8'(i));
      end
      chk("t3_count_full", {27'h0, count}, 32'd16);
      chk("t3_wr_ready_full", {31'h0, wr_ready}, 32'd0);
      chk("t3_overflow_pre", {31'h0, overflow}, 32'd0);
      push_byte(8'h70);
      chk("t3_overflow_set", {31'h0, overflow}, 32'd1);
      chk("t3_count_still_full", {27'h0, count}, 32'd16);
      tx_sent = 1'b1;
      wait_drain(1000);
      chk("t3_count_zero", {27'h0, count}, 32'd0);
      chk("t3_overflow_sticky", {31'h0, overflow}, 32'd1);

      // Test 4: loader stalls at full without loss; ld_start while busy.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(8'h80 + 8'(i));
         push_byte(8'h80 + 8'(i));
      end
      for (int i = 0; i < LC; i++) begin
         ld_line = {ld_line[8*LC-9:0], 8'hA0 + 8'(i)};
         exp_q.push_back(8'hA0 + 8'(i));
      end
      start_line(4'd14);
      repeat (10) tick();
      chk("t4_count_full", {27'h0, count}, 32'd16);
      chk("t4_ld_busy_stalled", {31'h0, ld_busy}, 32'd1);
      chk("t4_wr_ready", {31'h0, wr_ready}, 32'd0);
      chk("t4_ld_err_pre", {31'h0, ld_err}, 32'd0);
      start_line(4'd14);
      chk("t4_ld_err_set", {31'h0, ld_err}, 32'd1);
      tx_sent = 1'b1;
      wait_drain(1500);
      chk("t4_ld_busy_done", {31'h0, ld_busy}, 32'd0);
      chk("t4_count_zero", {27'h0, count}, 32'd0);
      chk("t4_ld_err_sticky", {31'h0, ld_err}, 32'd1);

      // Test 5: reset after 3 of 14 line bytes -> nothing more is sent.
      do_reset();
      tx_sent = 1'b1;
      ld_line = line1;
      for (int i = 0; i < 3; i++) exp_q.push_back(line1_b[i]);
      start_line(4'd14);
      wait_drain(200);
      do_reset();
      n_before = n_tx;
      tx_sent = 1'b1;
      repeat (100) tick();
      chk("t5_no_tx_after_reset", n_tx - n_before, 32'd0);
      chk("t5_count_zero", {27'h0, count}, 32'd0);
      chk("t5_ld_busy_zero", {31'h0, ld_busy}, 32'd0);

      // Test 6: ld_len==0 is a no-op; ld_len==15 clamps to 14 bytes.
      do_reset();
      ld_line = line1;
      start_line(4'd0);
      chk("t6_len0_not_busy", {31'h0, ld_busy}, 32'd0);
      tick();
      chk("t6_len0_count", {27'h0, count}, 32'd0);
      for (int i = 0; i < LC; i++) begin
         ld_line = {ld_line[8*LC-9:0], 8'hC0 + 8'(i)};
         exp_q.push_back(8'hC0 + 8'(i));
      end
      start_line(4'd15);
      repeat (20) tick();
      chk("t6_len15_count", {27'h0, count}, 32'd14);
      chk("t6_len15_not_busy", {31'h0, ld_busy}, 32'd0);
      chk("t6_ld_err_clear", {31'h0, ld_err}, 32'd0);
      tx_sent = 1'b1;
      wait_drain(600);
      chk("t6_count_zero", {27'h0, count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_uart_tx_queue
`default_nettype wire
